// File: rtl/mfp_spi_slave_responder_pkg.sv
// Shared types and defaults for the SPI slave responder.
// Frame layout: leading zeros, sample, trailing zeros.
package mfp_spi_slave_responder_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    localparam int DEF_FRAME_BITS = 16;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_LEAD_ZEROS = 3;

    function automatic int trail_zeros(
        input int fb,
        input int dw,
        input int lz
    );
        return fb - lz - dw;
    endfunction

endpackage

// File: rtl/mfp_spi_slave_responder_if.sv
// Bundle of SPI pins, sample handshake and frame status.
// master = SPI host / sample producer side, slave = responder.
interface mfp_spi_slave_responder_if #(
    parameter int FRAME_BITS = 16,
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  spi_cs_n;
    logic                  spi_sck;
    logic                  spi_mosi;
    logic                  spi_miso;
    logic                  spi_miso_oe;
    logic [FRAME_BITS-1:0] rx_data;
    logic                  rx_valid;
    logic                  frame_done;
    logic                  underrun;
    logic                  abort;

    modport master (
        output tx_data, tx_valid,
        output spi_cs_n, spi_sck, spi_mosi,
        input  tx_ready, spi_miso, spi_miso_oe,
        input  rx_data, rx_valid, frame_done,
        input  underrun, abort
    );

    modport slave (
        input  tx_data, tx_valid,
        input  spi_cs_n, spi_sck, spi_mosi,
        output tx_ready, spi_miso, spi_miso_oe,
        output rx_data, rx_valid, frame_done,
        output underrun, abort
    );

endinterface

// File: rtl/mfp_spi_slave_sync_edge.sv
// 2-FF synchronizer with a third stage for rise/fall pulses.
// Edges are masked until the pipeline holds real pin samples.
module mfp_spi_slave_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);
    logic       s1;
    logic       s2;
    logic       s3;
    logic [2:0] fill;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1   <= RST_VAL;
            s2   <= RST_VAL;
            s3   <= RST_VAL;
            fill <= '0;
        end else begin
            s1   <= din;
            s2   <= s1;
            s3   <= s2;
            fill <= {fill[1:0], 1'b1};
        end
    end

    // a level held through reset must not look like an edge
    assign dout = s2;
    assign rise = fill[2] & s2 & ~s3;
    assign fall = fill[2] & ~s2 & s3;

endmodule

// File: rtl/mfp_spi_slave_responder.sv
// SPI slave emulating an ADC081S021-style sensor, mode-3 timing,
// all pins oversampled on clk.
module mfp_spi_slave_responder
    import mfp_spi_slave_responder_pkg::*;
#(
    parameter int FRAME_BITS = DEF_FRAME_BITS,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEAD_ZEROS = DEF_LEAD_ZEROS
) (
    input  logic clk,
    input  logic resetn,
    mfp_spi_slave_responder_if.slave bus
);
    localparam int TRAIL =
        trail_zeros(FRAME_BITS, DATA_WIDTH, LEAD_ZEROS);
    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);

    if (TRAIL < 0) begin : g_cfg_err
        $error("LEAD_ZEROS + DATA_WIDTH exceeds FRAME_BITS");
    end

    logic cs_s, cs_rise, cs_fall;
    logic sck_s, sck_rise, sck_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic unused_sigs;

    mfp_spi_slave_sync_edge #(.RST_VAL(1'b1)) u_cs (
        .clk(clk), .resetn(resetn), .din(bus.spi_cs_n),
        .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
    );
    mfp_spi_slave_sync_edge #(.RST_VAL(1'b1)) u_sck (
        .clk(clk), .resetn(resetn), .din(bus.spi_sck),
        .dout(sck_s), .rise(sck_rise), .fall(sck_fall)
    );
    mfp_spi_slave_sync_edge #(.RST_VAL(1'b0)) u_mosi (
        .clk(clk), .resetn(resetn), .din(bus.spi_mosi),
        .dout(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );

    assign unused_sigs = &{1'b0, cs_s, sck_s, mosi_rise, mosi_fall};

    state_e                state, state_n;
    logic                  hold_full, hold_full_n;
    logic [DATA_WIDTH-1:0] hold_data, hold_data_n;
    logic [DATA_WIDTH-1:0] last_sample, last_n;
    logic [FRAME_BITS-1:0] tx_shift, tx_shift_n;
    logic [FRAME_BITS-1:0] rx_shift, rx_shift_n;
    logic [CNT_W-1:0]      bit_cnt, bit_cnt_n;
    logic                  done_pend, done_pend_n;
    logic [FRAME_BITS-1:0] rx_data_q, rx_data_n;
    logic                  rx_valid_q, rx_valid_n;
    logic                  frame_done_q, frame_done_n;
    logic                  underrun_q, underrun_n;
    logic                  abort_q, abort_n;
    logic                  miso_q, miso_n;
    logic                  oe_q, oe_n;
    logic [DATA_WIDTH-1:0] sample;
    logic [FRAME_BITS-1:0] tx_frame;

    // hold first, then same-cycle bypass, then repeat the last sample
    assign sample = hold_full    ? hold_data :
                    bus.tx_valid ? bus.tx_data : last_sample;
    assign tx_frame = FRAME_BITS'(sample) << TRAIL;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            hold_full    <= 1'b0;
            hold_data    <= '0;
            last_sample  <= '0;
            tx_shift     <= '0;
            rx_shift     <= '0;
            bit_cnt      <= '0;
            done_pend    <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
            abort_q      <= 1'b0;
            miso_q       <= 1'b0;
            oe_q         <= 1'b0;
        end else begin
            state        <= state_n;
            hold_full    <= hold_full_n;
            hold_data    <= hold_data_n;
            last_sample  <= last_n;
            tx_shift     <= tx_shift_n;
            rx_shift     <= rx_shift_n;
            bit_cnt      <= bit_cnt_n;
            done_pend    <= done_pend_n;
            rx_data_q    <= rx_data_n;
            rx_valid_q   <= rx_valid_n;
            frame_done_q <= frame_done_n;
            underrun_q   <= underrun_n;
            abort_q      <= abort_n;
            miso_q       <= miso_n;
            oe_q         <= oe_n;
        end
    end

    always_comb begin
        state_n      = state;
        hold_full_n  = hold_full;
        hold_data_n  = hold_data;
        last_n       = last_sample;
        tx_shift_n   = tx_shift;
        rx_shift_n   = rx_shift;
        bit_cnt_n    = bit_cnt;
        done_pend_n  = 1'b0;
        rx_data_n    = rx_data_q;
        rx_valid_n   = 1'b0;
        frame_done_n = 1'b0;
        underrun_n   = 1'b0;
        abort_n      = 1'b0;
        miso_n       = miso_q;
        oe_n         = oe_q;

        if (bus.tx_valid && !hold_full) begin
            hold_full_n = 1'b1;
            hold_data_n = bus.tx_data;
        end

        if (done_pend) begin
            rx_data_n    = rx_shift;
            rx_valid_n   = 1'b1;
            frame_done_n = 1'b1;
        end

        unique case (state)
            ST_IDLE: begin
                miso_n = 1'b0;
                oe_n   = 1'b0;
                if (cs_fall) begin
                    state_n     = ST_ACTIVE;
                    oe_n        = 1'b1;
                    hold_full_n = 1'b0;
                    underrun_n  = !hold_full && !bus.tx_valid;
                    last_n      = sample;
                    tx_shift_n  = tx_frame;
                    rx_shift_n  = '0;
                    bit_cnt_n   = '0;
                    miso_n      = tx_frame[FRAME_BITS-1];
                end
            end
            ST_ACTIVE: begin
                oe_n = 1'b1;
                if (cs_rise) begin
                    state_n = ST_IDLE;
                    oe_n    = 1'b0;
                    miso_n  = 1'b0;
                    abort_n = bit_cnt < CNT_MAX;
                end else if (sck_rise && bit_cnt < CNT_MAX) begin
                    rx_shift_n  = {rx_shift[FRAME_BITS-2:0], mosi_s};
                    bit_cnt_n   = bit_cnt + CNT_W'(1);
                    done_pend_n = bit_cnt == CNT_LAST;
                end else if (sck_fall && bit_cnt != '0) begin
                    // the leading fall before any rise is skipped above
                    if (bit_cnt < CNT_MAX) begin
                        tx_shift_n = tx_shift << 1;
                        miso_n     = tx_shift[FRAME_BITS-2];
                    end else begin
                        miso_n = 1'b0;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign bus.tx_ready    = ~hold_full;
    assign bus.spi_miso    = miso_q;
    assign bus.spi_miso_oe = oe_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.underrun    = underrun_q;
    assign bus.abort       = abort_q;

endmodule

// File: tb/tb_mfp_spi_slave_responder.sv
// Directed bench for mfp_spi_slave_responder, SCK = clk/8.
module tb_mfp_spi_slave_responder;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mfp_spi_slave_responder_if #(
        .FRAME_BITS(16), .DATA_WIDTH(8)
    ) bus ();

    mfp_spi_slave_responder #(
        .FRAME_BITS(16), .DATA_WIDTH(8), .LEAD_ZEROS(3)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int n_rx = 0;
    int n_done = 0;
    int n_under = 0;
    int n_abort = 0;
    logic [15:0] exp_rx[$];

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // pulse monitor and rx scoreboard
    always @(posedge clk) begin
        #2;
        if (bus.rx_valid === 1'b1) begin
            n_rx++;
            chk("rx_pending", 32'(exp_rx.size() > 0), 32'd1);
            if (exp_rx.size() > 0)
                chk("rx_data", 32'(bus.rx_data), 32'(exp_rx.pop_front()));
        end
        if (bus.frame_done === 1'b1) n_done++;
        if (bus.underrun === 1'b1) n_under++;
        if (bus.abort === 1'b1) n_abort++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic preload(input logic [7:0] d);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        tick(1);
        bus.tx_valid = 1'b0;
        tick(1);
    endtask

    task automatic cs_low();
        bus.spi_cs_n = 1'b0;
        tick(6);
    endtask

    task automatic cs_high();
        bus.spi_cs_n = 1'b1;
        tick(6);
    endtask

    task automatic shift_bits(input logic [15:0] mw, input int n,
                              output logic [15:0] sw);
        sw = '0;
        for (int i = 0; i < n; i++) begin
            bus.spi_sck  = 1'b0;
            bus.spi_mosi = mw[15-i];
            tick(4);
            sw[15-i]    = bus.spi_miso;
            bus.spi_sck = 1'b1;
            tick(4);
        end
        tick(4);
    endtask

    logic [15:0] got;
    int d_rx, d_done, d_under, d_abort;

    task automatic snap();
        d_rx = n_rx;
        d_done = n_done;
        d_under = n_under;
        d_abort = n_abort;
    endtask

    initial begin
        resetn       = 1'b0;
        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.spi_sck  = 1'b1;
        bus.spi_mosi = 1'b0;
        tick(3);
        chk("rst_miso", 32'(bus.spi_miso), 0);
        chk("rst_oe", 32'(bus.spi_miso_oe), 0);
        chk("rst_rx_data", 32'(bus.rx_data), 0);
        chk("rst_tx_ready", 32'(bus.tx_ready), 1);
        chk("rst_pulses", 32'({bus.rx_valid, bus.frame_done,
                               bus.underrun, bus.abort}), 0);
        resetn = 1'b1;
        tick(4);

        // frame 1: preloaded A5
        preload(8'hA5);
        chk("t1_ready_full", 32'(bus.tx_ready), 0);
        snap();
        exp_rx.push_back(16'h5A5A);
        cs_low();
        chk("t1_ready_after_fall", 32'(bus.tx_ready), 1);
        chk("t1_oe_sel", 32'(bus.spi_miso_oe), 1);
        shift_bits(16'h5A5A, 16, got);
        chk("t1_miso", 32'(got), 32'h14A0);
        chk("t1_done", 32'(n_done - d_done), 1);
        chk("t1_under", 32'(n_under - d_under), 0);
        cs_high();
        chk("t1_oe_desel", 32'(bus.spi_miso_oe), 0);

        // frame 2: receive C3F0
        preload(8'hA5);
        snap();
        exp_rx.push_back(16'hC3F0);
        chk("t2_oe_idle", 32'(bus.spi_miso_oe), 0);
        cs_low();
        chk("t2_oe_sel", 32'(bus.spi_miso_oe), 1);
        shift_bits(16'hC3F0, 16, got);
        chk("t2_miso", 32'(got), 32'h14A0);
        chk("t2_rx_pulses", 32'(n_rx - d_rx), 1);
        chk("t2_rx_data", 32'(bus.rx_data), 32'hC3F0);
        cs_high();
        chk("t2_oe_desel", 32'(bus.spi_miso_oe), 0);

        // frame 3: underrun repeats last sample
        snap();
        exp_rx.push_back(16'h0F0F);
        cs_low();
        chk("t3_under", 32'(n_under - d_under), 1);
        shift_bits(16'h0F0F, 16, got);
        chk("t3_miso", 32'(got), 32'h14A0);
        cs_high();

        // frame 4: bypass on the cs_fall detect cycle
        snap();
        exp_rx.push_back(16'h1234);
        bus.spi_cs_n = 1'b0;
        tick(2);
        bus.tx_data  = 8'h3C;
        bus.tx_valid = 1'b1;
        tick(1);
        bus.tx_valid = 1'b0;
        chk("t4_ready", 32'(bus.tx_ready), 1);
        tick(3);
        chk("t4_oe", 32'(bus.spi_miso_oe), 1);
        chk("t4_under", 32'(n_under - d_under), 0);
        shift_bits(16'h1234, 16, got);
        chk("t4_miso", 32'(got), 32'h0780);
        chk("t4_ready_end", 32'(bus.tx_ready), 1);
        cs_high();

        // frame 5: abort after 7 bits, then a normal frame
        snap();
        cs_low();
        shift_bits(16'hFFFF, 7, got);
        chk("t5_partial_miso", 32'(got), 32'h0600);
        cs_high();
        chk("t5_abort", 32'(n_abort - d_abort), 1);
        chk("t5_no_rx", 32'(n_rx - d_rx), 0);
        chk("t5_rx_kept", 32'(bus.rx_data), 32'h1234);
        chk("t5_under", 32'(n_under - d_under), 1);
        preload(8'h5C);
        snap();
        exp_rx.push_back(16'h6E6E);
        cs_low();
        shift_bits(16'h6E6E, 16, got);
        chk("t5b_miso", 32'(got), 32'h0B80);
        chk("t5b_done", 32'(n_done - d_done), 1);
        cs_high();
        chk("t5b_no_abort", 32'(n_abort - d_abort), 0);

        // frame 6: reset mid-frame with CS held low
        preload(8'h11);
        cs_low();
        shift_bits(16'hAAAA, 5, got);
        resetn = 1'b0;
        tick(3);
        chk("t6_rst_oe", 32'(bus.spi_miso_oe), 0);
        chk("t6_rst_miso", 32'(bus.spi_miso), 0);
        chk("t6_rst_rx", 32'(bus.rx_data), 0);
        chk("t6_rst_ready", 32'(bus.tx_ready), 1);
        resetn = 1'b1;
        snap();
        for (int i = 0; i < 6; i++) begin
            bus.spi_sck  = ~bus.spi_sck;
            bus.spi_mosi = ~bus.spi_mosi;
            tick(4);
        end
        bus.spi_sck = 1'b1;
        tick(4);
        chk("t6_idle_oe", 32'(bus.spi_miso_oe), 0);
        chk("t6_idle_miso", 32'(bus.spi_miso), 0);
        chk("t6_idle_pulses", 32'(n_rx - d_rx + n_done - d_done
                                  + n_under - d_under), 0);
        cs_high();
        chk("t6_no_abort", 32'(n_abort - d_abort), 0);
        preload(8'hE7);
        snap();
        exp_rx.push_back(16'h9A9A);
        cs_low();
        chk("t6_oe", 32'(bus.spi_miso_oe), 1);
        chk("t6_under", 32'(n_under - d_under), 0);
        shift_bits(16'h9A9A, 16, got);
        chk("t6_miso", 32'(got), 32'h1CE0);
        chk("t6_done", 32'(n_done - d_done), 1);
        cs_high();

        chk("sb_empty", 32'(exp_rx.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
